// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and types for the serial packed-BCD add/subtract engine
package bcd_pkg;

    localparam int         BCD_W      = 4;
    localparam logic [3:0] BCD_NINE   = 4'd9;
    localparam logic [3:0] BCD_CORR   = 4'd6;

    localparam logic       BCD_OP_ADD = 1'b0;
    localparam logic       BCD_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_seq_state_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - combinational single-digit BCD adder with decimal correction
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             ci,
    output logic [BCD_W-1:0] d,
    output logic             co
);

    logic [BCD_W:0] t;

    // Non-BCD input digits still follow the same rule so results stay deterministic.
    always_comb begin
        t = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
        if (t > 5'd9) begin
            d  = t[BCD_W-1:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            d  = t[BCD_W-1:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD add/subtract, one digit per cycle, LSD first
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = $clog2(DIGITS);

    bcd_seq_state_t      state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic                op_r;
    logic [4*DIGITS-1:0] a_r;
    logic [4*DIGITS-1:0] b_r;
    logic [4*DIGITS-1:0] sum_r;
    logic                err_r;

    logic [BCD_W-1:0]    a_dig;
    logic [BCD_W-1:0]    b_dig;
    logic [BCD_W-1:0]    y_dig;
    logic [BCD_W-1:0]    cell_d;
    logic                cell_co;

    assign a_dig = a_r[BCD_W*int'(idx) +: BCD_W];
    assign b_dig = b_r[BCD_W*int'(idx) +: BCD_W];
    // Subtract is nines-complement of B plus an initial carry of 1.
    assign y_dig = (op_r == BCD_OP_SUB) ? BCD_NINE - b_dig : b_dig;

    bcd_digit_cell u_cell (
        .x  (a_dig),
        .y  (y_dig),
        .ci (carry),
        .d  (cell_d),
        .co (cell_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            op_r  <= BCD_OP_ADD;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
                        err_r <= 1'b0;
                        idx   <= '0;
                        carry <= (op == BCD_OP_SUB) ? 1'b1 : cin;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[BCD_W*int'(idx) +: BCD_W] <= cell_d;
                    carry <= cell_co;
                    err_r <= err_r | (a_dig > BCD_NINE) | (b_dig > BCD_NINE);
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = carry;
    assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - randomized and directed self-checking bench for bcd_serial_addsub
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int n_pass = 0;
    int n_total = 0;
    int lat;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int to_dec(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Issue one request and wait (bounded) until out_valid; leaves the block in DONE.
    task automatic do_req(input logic o, input logic c, input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_req", in_ready, 1'b1);
        in_valid = 1'b1; op = o; cin = c; a = av; b = bv;
        lat = 0;
        guard = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom; b = $urandom;
            guard++;
        end while (!out_valid && guard < 50);
        if (guard >= 50) check("out_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", in_ready, 1'b1);
        check("out_valid_after_handshake", out_valid, 1'b0);
    endtask

    task automatic run_check(input string tag, input logic o, input logic c,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] es, input logic ec, input logic ee);
        do_req(o, c, av, bv);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_err"}, err, ee);
        check({tag, "_latency"}, lat, DIGITS + 1);
        release_out();
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        logic         hold_err;
        rst = 1'b1; in_valid = 1'b0; op = 1'b0; cin = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 1'b0);
        check("reset_err", err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);

        run_check("add_1234_5678", 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        run_check("add_9999_cin",  1'b0, 1'b1, 16'h9999, 16'h0000, 16'h0000, 1'b1, 1'b0);
        run_check("sub_5000_1234", 1'b1, 1'b0, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0);
        run_check("sub_1234_5000", 1'b1, 1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0);
        run_check("add_invalid",   1'b0, 1'b0, 16'h00A0, 16'h0001, 16'h0101, 1'b0, 1'b1);
        run_check("err_clears",    1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0);

        // Backpressure: outputs frozen, in_valid ignored while DONE.
        do_req(1'b0, 1'b0, 16'h0456, 16'h0789);
        hold_sum = sum; hold_cout = cout; hold_err = err;
        check("bp_sum", hold_sum, 16'h1245);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1); a = 16'h1111; b = 16'h2222;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sum_stable", sum, hold_sum);
            check("bp_cout_stable", cout, hold_cout);
            check("bp_err_stable", err, hold_err);
        end
        release_out();
        check("bp_sum_after", sum, 16'h1245);

        // Reset on the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1; op = 1'b0; cin = 1'b0; a = 16'h4321; b = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1'b0);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_cout", cout, 1'b0);
        check("rst_mid_err", err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_no_out_valid", out_valid, 1'b0);
        end
        run_check("after_rst_add", 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        // Randomized valid-BCD traffic against a decimal-arithmetic model.
        for (int n = 0; n < 30; n++) begin
            int da, db, res;
            logic o, c, ec;
            da = int'($urandom_range(0, MODV - 1));
            db = int'($urandom_range(0, MODV - 1));
            o = 1'($urandom);
            c = 1'($urandom);
            if (o) begin
                res = MODV + da - db;
                ec  = (da >= db);
            end else begin
                res = da + db + int'(c);
                ec  = (res >= MODV);
            end
            run_check("rand", o, c, to_bcd(da), to_bcd(db), to_bcd(res % MODV), ec, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
